// File: rtl/rtc_bus_ctrl_if.sv
// User-side request/response bundle for the RTC bus sequencer.
// The master is the user FSM; the slave is rtc_bus_ctrl.
interface rtc_bus_ctrl_if;
   logic       start;
   logic       rw;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata;

   modport master (
      output start, rw, addr, wdata,
      input  busy, done, rdata
   );

   modport slave (
      input  start, rw, addr, wdata,
      output busy, done, rdata
   );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Sequences one multiplexed address/data RTC transaction (CS#, A/D, RD#, WR#)
// and steers the 8-bit pad buffer; every pin output is set on state entry.
module rtc_bus_ctrl #(
   parameter int unsigned T_SETUP   = 2,
   parameter int unsigned T_STROBE  = 4,
   parameter int unsigned T_HOLD    = 2,
   parameter int unsigned T_RECOVER = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   rtc_bus_ctrl_if.slave       bus,
   output logic                dir_in,
   output logic [7:0]          bus_out,
   input  logic [7:0]          bus_in,
   output logic                cs_n,
   output logic                ad,
   output logic                rd_n,
   output logic                wr_n
);

   typedef enum logic [2:0] {
      IDLE,
      A_SETUP,
      A_STROBE,
      A_HOLD,
      D_SETUP,
      D_STROBE,
      D_HOLD,
      RECOVER
   } state_t;

   // Counter is loaded with duration-1 and the state advances when it hits zero.
   localparam logic [3:0] LD_SETUP   = 4'(T_SETUP - 1);
   localparam logic [3:0] LD_STROBE  = 4'(T_STROBE - 1);
   localparam logic [3:0] LD_HOLD    = 4'(T_HOLD - 1);
   localparam logic [3:0] LD_RECOVER = 4'(T_RECOVER - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       rw_q;
   logic [7:0] wdata_q;
   logic       done_q;
   logic [7:0] rdata_q;

   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_q;
   assign bus.rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         dir_in  <= 1'b1;
         bus_out <= '0;
         cs_n    <= 1'b1;
         ad      <= 1'b1;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               rw_q    <= bus.rw;
               wdata_q <= bus.wdata;
               bus_out <= bus.addr;
               cs_n    <= 1'b0;
               ad      <= 1'b0;
               dir_in  <= 1'b0;
               state   <= A_SETUP;
               cnt     <= LD_SETUP;
            end
         end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
         end else begin
            case (state)
               A_SETUP: begin
                  wr_n  <= 1'b0;
                  state <= A_STROBE;
                  cnt   <= LD_STROBE;
               end
               A_STROBE: begin
                  wr_n  <= 1'b1;
                  state <= A_HOLD;
                  cnt   <= LD_HOLD;
               end
               A_HOLD: begin
                  ad <= 1'b1;
                  if (rw_q) dir_in  <= 1'b1;
                  else      bus_out <= wdata_q;
                  state <= D_SETUP;
                  cnt   <= LD_SETUP;
               end
               D_SETUP: begin
                  if (rw_q) rd_n <= 1'b0;
                  else      wr_n <= 1'b0;
                  state <= D_STROBE;
                  cnt   <= LD_STROBE;
               end
               D_STROBE: begin
                  // bus_in here is the buffer's copy of the pad from inside the strobe window.
                  rd_n <= 1'b1;
                  wr_n <= 1'b1;
                  if (rw_q) rdata_q <= bus_in;
                  state <= D_HOLD;
                  cnt   <= LD_HOLD;
               end
               D_HOLD: begin
                  cs_n   <= 1'b1;
                  dir_in <= 1'b1;
                  ad     <= 1'b1;
                  state  <= RECOVER;
                  cnt    <= LD_RECOVER;
               end
               RECOVER: begin
                  done_q <= 1'b1;
                  state  <= IDLE;
                  cnt    <= '0;
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: offset-based transaction model, directed literal
// checks for the documented timings, then randomized traffic with resets.
module tb_rtc_bus_ctrl;

   localparam int S  = 2;
   localparam int ST = 4;
   localparam int H  = 2;
   localparam int R  = 4;
   // Offsets (cycles after acceptance) at which each phase ends.
   localparam int B1 = S;
   localparam int B2 = B1 + ST;
   localparam int B3 = B2 + H;
   localparam int B4 = B3 + S;
   localparam int B5 = B4 + ST;
   localparam int B6 = B5 + H;
   localparam int L  = B6 + R;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       dir_in;
   logic [7:0] bus_out;
   logic [7:0] bus_in = 8'h00;
   logic       cs_n, ad, rd_n, wr_n;
   logic [7:0] rtc_drive = 8'h00;
   logic [7:0] pad;

   rtc_bus_ctrl_if ifc ();

   rtc_bus_ctrl #(
      .T_SETUP  (S),
      .T_STROBE (ST),
      .T_HOLD   (H),
      .T_RECOVER(R)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (ifc.slave),
      .dir_in (dir_in),
      .bus_out(bus_out),
      .bus_in (bus_in),
      .cs_n   (cs_n),
      .ad     (ad),
      .rd_n   (rd_n),
      .wr_n   (wr_n)
   );

   always #5 clk = ~clk;

   // Pad: controller drives when dir_in=0, the RTC drives during rd_n low, otherwise junk.
   assign pad = !dir_in ? bus_out : (!rd_n ? rtc_drive : ~rtc_drive);
   always @(posedge clk) bus_in <= pad;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a transaction is just an offset 1..L from its accepting edge.
   bit         m_active = 1'b0;
   int         m_k = 0;
   bit         m_rw = 1'b0;
   logic [7:0] m_wdata = 8'h00;
   logic [7:0] m_rtc = 8'h00;
   logic [7:0] m_bus_out = 8'h00;
   logic [7:0] m_rdata = 8'h00;
   bit         m_done = 1'b0;
   int         m_done_total = 0;
   int         dut_dones = 0;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_active  <= 1'b0;
         m_k       <= 0;
         m_done    <= 1'b0;
         m_rdata   <= 8'h00;
         m_bus_out <= 8'h00;
      end else if (!m_active) begin
         m_done <= 1'b0;
         if (ifc.start) begin
            m_active  <= 1'b1;
            m_k       <= 1;
            m_rw      <= ifc.rw;
            m_wdata   <= ifc.wdata;
            m_bus_out <= ifc.addr;
            m_rtc     <= rtc_drive;
         end
      end else begin
         if (m_k == L) begin
            m_active     <= 1'b0;
            m_done       <= 1'b1;
            m_done_total <= m_done_total + 1;
         end else begin
            m_k <= m_k + 1;
         end
         if (!m_rw && m_k == B3) m_bus_out <= m_wdata;
         if (m_rw && m_k == B5)  m_rdata   <= m_rtc;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         automatic bit a    = m_active;
         automatic int k    = m_k;
         automatic bit e_cs = !(a && k <= B6);
         automatic bit e_ad = !(a && k <= B3);
         automatic bit e_wr = !(a && ((k > B1 && k <= B2) || (!m_rw && k > B4 && k <= B5)));
         automatic bit e_rd = !(a && m_rw && k > B4 && k <= B5);
         automatic bit e_dir = !(a && (k <= B3 || (!m_rw && k <= B6)));
         check("busy",    32'(ifc.busy),  32'(a));
         check("done",    32'(ifc.done),  32'(m_done));
         check("cs_n",    32'(cs_n),      32'(e_cs));
         check("ad",      32'(ad),        32'(e_ad));
         check("wr_n",    32'(wr_n),      32'(e_wr));
         check("rd_n",    32'(rd_n),      32'(e_rd));
         check("dir_in",  32'(dir_in),    32'(e_dir));
         check("bus_out", 32'(bus_out),   32'(m_bus_out));
         check("rdata",   32'(ifc.rdata), 32'(m_rdata));
         check("strobe_overlap", 32'(rd_n | wr_n), 32'd1);
         check("drive_without_cs", 32'(!dir_in && cs_n), 32'd0);
         check("drive_during_rd", 32'(!rd_n && !dir_in), 32'd0);
         if (ifc.done === 1'b1) dut_dones++;
      end
   end

   initial begin
      ifc.start = 1'b0;
      ifc.rw    = 1'b0;
      ifc.addr  = 8'h00;
      ifc.wdata = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      reset_n = 1'b1;
      check("reset_cs_n", 32'(cs_n), 32'd1);
      check("reset_dir_in", 32'(dir_in), 32'd1);
      check("reset_bus_out", 32'(bus_out), 32'h00);
      @(negedge clk);

      // Directed write: addr 21, data 5A
      ifc.start = 1'b1; ifc.rw = 1'b0; ifc.addr = 8'h21; ifc.wdata = 8'h5A;
      @(negedge clk);
      for (int n = 1; n <= 22; n++) begin
         ifc.start = 1'b0;
         if (n == 2)  check("w_wr_n_c2", 32'(wr_n), 32'd1);
         if (n == 3)  begin check("w_pad_c3", 32'(pad), 32'h21); check("w_wr_n_c3", 32'(wr_n), 32'd0); end
         if (n == 8)  check("w_ad_c8", 32'(ad), 32'd0);
         if (n == 9)  check("w_ad_c9", 32'(ad), 32'd1);
         if (n == 11) begin check("w_pad_c11", 32'(pad), 32'h5A); check("w_wr_n_c11", 32'(wr_n), 32'd0); end
         if (n == 16) begin check("w_pad_c16", 32'(pad), 32'h5A); check("w_cs_n_c16", 32'(cs_n), 32'd0); end
         if (n == 17) check("w_cs_n_c17", 32'(cs_n), 32'd1);
         if (n == 20) check("w_done_c20", 32'(ifc.done), 32'd0);
         if (n == 21) check("w_done_c21", 32'(ifc.done), 32'd1);
         if (n == 22) check("w_done_c22", 32'(ifc.done), 32'd0);
         @(negedge clk);
      end

      // Directed read: addr 22, RTC answers C3
      ifc.start = 1'b1; ifc.rw = 1'b1; ifc.addr = 8'h22; rtc_drive = 8'hC3;
      @(negedge clk);
      for (int n = 1; n <= 22; n++) begin
         ifc.start = 1'b0;
         if (n == 8)  check("r_dir_c8", 32'(dir_in), 32'd0);
         if (n == 9)  check("r_dir_c9", 32'(dir_in), 32'd1);
         if (n == 10) check("r_rd_n_c10", 32'(rd_n), 32'd1);
         if (n == 11) check("r_rd_n_c11", 32'(rd_n), 32'd0);
         if (n == 14) begin check("r_rd_n_c14", 32'(rd_n), 32'd0); check("r_rdata_c14", 32'(ifc.rdata), 32'h00); end
         if (n == 15) begin check("r_rd_n_c15", 32'(rd_n), 32'd1); check("r_rdata_c15", 32'(ifc.rdata), 32'hC3); end
         if (n == 21) check("r_done_c21", 32'(ifc.done), 32'd1);
         @(negedge clk);
      end

      // Back-to-back: start held through the first transaction
      ifc.start = 1'b1; ifc.rw = 1'b0; ifc.addr = 8'h30; ifc.wdata = 8'h99;
      @(negedge clk);
      for (int n = 1; n <= 44; n++) begin
         if (n == 22) ifc.start = 1'b0;
         if (n == 21) begin check("b_busy_c21", 32'(ifc.busy), 32'd0); check("b_done_c21", 32'(ifc.done), 32'd1); end
         if (n == 22) begin check("b_busy_c22", 32'(ifc.busy), 32'd1); check("b_cs_n_c22", 32'(cs_n), 32'd0); end
         if (n == 42) check("b_done_c42", 32'(ifc.done), 32'd1);
         if (n == 43) check("b_busy_c43", 32'(ifc.busy), 32'd0);
         @(negedge clk);
      end

      // Reset during the write data strobe
      ifc.start = 1'b1; ifc.rw = 1'b0; ifc.addr = 8'h44; ifc.wdata = 8'hA5;
      @(negedge clk);
      for (int n = 1; n <= 40; n++) begin
         ifc.start = 1'b0;
         if (n == 12) begin check("x_wr_n_c12", 32'(wr_n), 32'd0); reset_n = 1'b0; end
         if (n == 13) begin
            reset_n = 1'b1;
            check("x_cs_n", 32'(cs_n), 32'd1);
            check("x_wr_n", 32'(wr_n), 32'd1);
            check("x_bus_out", 32'(bus_out), 32'h00);
            check("x_rdata", 32'(ifc.rdata), 32'h00);
            check("x_busy", 32'(ifc.busy), 32'd0);
         end
         if (n > 13) check("x_no_done", 32'(ifc.done), 32'd0);
         @(negedge clk);
      end

      // Randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         ifc.start = ($urandom_range(0, 3) == 0);
         ifc.rw    = 1'($urandom);
         ifc.addr  = 8'($urandom);
         ifc.wdata = 8'($urandom);
         if (!m_active) rtc_drive = 8'($urandom);
         reset_n = ($urandom_range(0, 399) != 0);
         @(negedge clk);
      end
      ifc.start = 1'b0;
      reset_n = 1'b1;
      repeat (30) @(negedge clk);

      check("done_count", 32'(dut_dones), 32'(m_done_total));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
